memory_pipe_be: RTL and testbench

MEMORY_PIPE_BE -- requirements
Module: memory_pipe_be

---
 rtl/memory_pipe_be.sv | 105 ++++++++++
 tb/tb_memory_pipe_be.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/memory_pipe_be.sv
// Byte-enabled word memory with a fixed-latency, fully pipelined response path.
// Each accepted request travels through RD_LATENCY stages of {valid, error, data}.
module memory_pipe_be #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    response,
  output logic                    error
);

  localparam int NB = DATA_WIDTH / 8;
  // One extra bit so MEM_SIZE == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0] mem_d [MEM_SIZE];
  logic [RD_LATENCY-1:0] vld_q;
  logic [RD_LATENCY-1:0] err_q;
  logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];

  logic                  req_s;
  logic                  in_range_s;
  logic                  err_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] stage_data_s;

  // Request classification
  always_comb begin
    req_s      = wr | rd;
    in_range_s = ({1'b0, addr} < MEM_LIMIT);
    err_s      = req_s & ((wr & rd) | ~in_range_s);
    wr_ok_s    = wr & ~rd & in_range_s;
    rd_ok_s    = rd & ~wr & in_range_s;
  end

  // Read mux and first-stage data; writes and errors carry zero data
  always_comb begin
    rd_word_s = '0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      rd_word_s = rd_word_s | ((addr == ADDR_WIDTH'(i)) ? mem_q[i] : '0);
    end
    stage_data_s = rd_ok_s ? rd_word_s : '0;
  end

  // Byte-masked memory next state
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < MEM_SIZE; i++) begin
      for (int b = 0; b < NB; b++) begin
        mem_d[i][8*b +: 8] = (wr_ok_s && (addr == ADDR_WIDTH'(i)) && be[b])
                             ? wdata[8*b +: 8] : mem_q[i][8*b +: 8];
      end
    end
  end

  // Memory storage, cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Response pipeline; reset drops anything in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      err_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        dat_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= req_s;
      err_q[0] <= err_s;
      dat_q[0] <= stage_data_s;
      for (int s = 1; s < RD_LATENCY; s++) begin
        vld_q[s] <= vld_q[s-1];
        err_q[s] <= err_q[s-1];
        dat_q[s] <= dat_q[s-1];
      end
    end
  end

  assign response = vld_q[RD_LATENCY-1];
  assign error    = err_q[RD_LATENCY-1];
  assign rdata    = dat_q[RD_LATENCY-1];

endmodule

// File: tb/tb_memory_pipe_be.sv
// Directed bench for memory_pipe_be with ADDR_WIDTH=4, MEM_SIZE=12, RD_LATENCY=2.
module tb_memory_pipe_be;

  logic        clk;
  logic        reset;
  logic        wr;
  logic        rd;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        response;
  logic        error;

  int n_vec;
  int n_miss;

  // Expectation of the request issued one call earlier (it responds after the next edge)
  string       pend_tag;
  logic        pend_resp;
  logic        pend_err;
  logic [31:0] pend_data;

  memory_pipe_be #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(32),
    .MEM_SIZE  (12),
    .RD_LATENCY(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .wdata   (wdata),
    .be      (be),
    .rdata   (rdata),
    .response(response),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, clock it, then check the response due now
  task automatic cyc(input string tag, input logic w, input logic r, input logic [3:0] a,
                     input logic [31:0] d, input logic [3:0] b,
                     input logic e_resp, input logic e_err, input logic [31:0] e_data);
    wr = w; rd = r; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    chk({pend_tag, ".response"}, {31'd0, response}, {31'd0, pend_resp});
    chk({pend_tag, ".error"},    {31'd0, error},    {31'd0, pend_err});
    chk({pend_tag, ".rdata"},    rdata,             pend_data);
    pend_tag  = tag;
    pend_resp = e_resp;
    pend_err  = e_err;
    pend_data = e_data;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    pend_tag = "idle0"; pend_resp = 1'b0; pend_err = 1'b0; pend_data = 32'd0;
    reset = 1'b0; wr = 1'b0; rd = 1'b1; addr = 4'd0; wdata = 32'd0; be = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.response", {31'd0, response}, 32'd0);
    chk("reset.error",    {31'd0, error},    32'd0);
    chk("reset.rdata",    rdata,             32'd0);
    rd = 1'b0;
    reset = 1'b1;

    // Full write then read back
    cyc("wr3_full",  1'b1, 1'b0, 4'd3, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'd0);
    cyc("rd3_a",     1'b0, 1'b1, 4'd3, 32'd0,        4'h0, 1'b1, 1'b0, 32'hDEADBEEF);
    // Partial byte write on bytes 0 and 2
    cyc("wr3_be5",   1'b1, 1'b0, 4'd3, 32'h11223344, 4'h5, 1'b1, 1'b0, 32'd0);
    cyc("rd3_b",     1'b0, 1'b1, 4'd3, 32'd0,        4'h0, 1'b1, 1'b0, 32'hDE22BE44);
    // Out-of-range addresses
    cyc("rd12_err",  1'b0, 1'b1, 4'd12, 32'd0,        4'h0, 1'b1, 1'b1, 32'd0);
    cyc("wr15_err",  1'b1, 1'b0, 4'd15, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'd0);
    cyc("rd12",      1'b0, 1'b1, 4'd12, 32'd0, 4'h0, 1'b1, 1'b1, 32'd0);
    cyc("rd13",      1'b0, 1'b1, 4'd13, 32'd0, 4'h0, 1'b1, 1'b1, 32'd0);
    cyc("rd14",      1'b0, 1'b1, 4'd14, 32'd0, 4'h0, 1'b1, 1'b1, 32'd0);
    cyc("rd15",      1'b0, 1'b1, 4'd15, 32'd0, 4'h0, 1'b1, 1'b1, 32'd0);
    cyc("rd3_c",     1'b0, 1'b1, 4'd3,  32'd0, 4'h0, 1'b1, 1'b0, 32'hDE22BE44);
    cyc("rd11",      1'b0, 1'b1, 4'd11, 32'd0, 4'h0, 1'b1, 1'b0, 32'd0);
    // Simultaneous wr and rd is rejected without touching memory
    cyc("wr0",       1'b1, 1'b0, 4'd0, 32'hA5A50000, 4'hF, 1'b1, 1'b0, 32'd0);
    cyc("wrrd0_err", 1'b1, 1'b1, 4'd0, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'd0);
    cyc("rd0_a",     1'b0, 1'b1, 4'd0, 32'd0,        4'h0, 1'b1, 1'b0, 32'hA5A50000);
    // Zero byte enables: no update, still a clean response
    cyc("wr3_be0",   1'b1, 1'b0, 4'd3, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 32'd0);
    cyc("rd3_d",     1'b0, 1'b1, 4'd3, 32'd0,        4'h0, 1'b1, 1'b0, 32'hDE22BE44);
    // Single high byte enable
    cyc("wr1",       1'b1, 1'b0, 4'd1, 32'h01010101, 4'hF, 1'b1, 1'b0, 32'd0);
    cyc("wr1_be8",   1'b1, 1'b0, 4'd1, 32'h77FFFFFF, 4'h8, 1'b1, 1'b0, 32'd0);
    cyc("wr2",       1'b1, 1'b0, 4'd2, 32'h02020202, 4'hF, 1'b1, 1'b0, 32'd0);
    cyc("wr4",       1'b1, 1'b0, 4'd4, 32'h04040404, 4'hF, 1'b1, 1'b0, 32'd0);
    // Five back-to-back reads
    cyc("burst_rd0", 1'b0, 1'b1, 4'd0, 32'd0, 4'h0, 1'b1, 1'b0, 32'hA5A50000);
    cyc("burst_rd1", 1'b0, 1'b1, 4'd1, 32'd0, 4'h0, 1'b1, 1'b0, 32'h77010101);
    cyc("burst_rd2", 1'b0, 1'b1, 4'd2, 32'd0, 4'h0, 1'b1, 1'b0, 32'h02020202);
    cyc("burst_rd3", 1'b0, 1'b1, 4'd3, 32'd0, 4'h0, 1'b1, 1'b0, 32'hDE22BE44);
    cyc("burst_rd4", 1'b0, 1'b1, 4'd4, 32'd0, 4'h0, 1'b1, 1'b0, 32'h04040404);
    // Write immediately followed by read of the same word
    cyc("b2b_wr7",   1'b1, 1'b0, 4'd7, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 32'd0);
    cyc("b2b_rd7",   1'b0, 1'b1, 4'd7, 32'd0,        4'h0, 1'b1, 1'b0, 32'hCAFEF00D);
    idle("gap_a");
    idle("gap_b");
    idle("gap_c");

    // Write in flight when reset asserts must vanish
    cyc("wr5_lost",  1'b1, 1'b0, 4'd5, 32'h55555555, 4'hF, 1'b1, 1'b0, 32'd0);
    wr = 1'b0; rd = 1'b1; addr = 4'd3;
    reset = 1'b0;
    #1;
    chk("async_rst.response", {31'd0, response}, 32'd0);
    chk("async_rst.rdata",    rdata,             32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("in_rst.response", {31'd0, response}, 32'd0);
    rd = 1'b0;
    reset = 1'b1;
    pend_tag = "post_rst"; pend_resp = 1'b0; pend_err = 1'b0; pend_data = 32'd0;
    idle("post_rst_a");
    idle("post_rst_b");
    cyc("rd5_rst",   1'b0, 1'b1, 4'd5, 32'd0, 4'h0, 1'b1, 1'b0, 32'd0);
    cyc("rd3_rst",   1'b0, 1'b1, 4'd3, 32'd0, 4'h0, 1'b1, 1'b0, 32'd0);
    idle("end_a");
    idle("end_b");
    idle("end_c");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
